// File: rtl/axioma_flash_prog_seq.sv
// Flash self-programming sequencer: erase, load 64 words, write one page.
// Optional AXIOMA_FLASH_PROG_CHECKSUM_EN builds a mod-256 page byte sum.
module axioma_flash_prog_seq #(
   parameter int PAGE_WORDS     = 64,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_page,
   input  logic        cmd_abort,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        boot_enable,
   output logic        boot_erase,
   output logic        page_buffer_load,
   output logic        page_write_enable,
   output logic [5:0]  page_addr,
   output logic [15:0] boot_addr,
   output logic [15:0] boot_data,
   input  logic        flash_busy,
   output logic        seq_busy,
   output logic        seq_done,
   output logic        seq_error,
   output logic [7:0]  page_checksum
);

   typedef enum logic [3:0] {
      IDLE,
      ENABLE,
      ERASE_REQ,
      ERASE_WAIT_HI,
      ERASE_WAIT_LO,
      LOAD,
      LOAD_PULSE,
      WRITE_REQ,
      WRITE_WAIT_HI,
      WRITE_WAIT_LO,
      DONE,
      ERROR
   } state_t;

   localparam logic [5:0] LAST_IDX = 6'(PAGE_WORDS - 1);
   localparam logic [7:0] WD_LAST  = 8'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [5:0]  page_q, page_d;
   logic [7:0]  lo_q, lo_d;
   logic        phase_q, phase_d;
   logic [7:0]  wd_q, wd_d;
   logic        err_q, err_d;
   logic [15:0] bdata_q, bdata_d;
   logic [15:0] baddr_q, baddr_d;

   logic        ready_q, ready_d;
   logic        enable_q, enable_d;
   logic        erase_q, erase_d;
   logic        load_q, load_d;
   logic        write_q, write_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        accept;
   logic        start_ok;

   assign accept   = byte_valid && ready_q;
   assign start_ok = (state_q == IDLE) && cmd_start && !cmd_abort;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      page_d  = page_q;
      lo_d    = lo_q;
      phase_d = phase_q;
      wd_d    = wd_q;
      err_d   = err_q;
      bdata_d = bdata_q;
      baddr_d = baddr_q;

      unique case (state_q)
         IDLE: begin
            if (cmd_start) begin
               page_d  = cmd_page;
               err_d   = 1'b0;
               idx_d   = '0;
               phase_d = 1'b0;
               state_d = ENABLE;
            end
         end
         ENABLE: state_d = ERASE_REQ;
         ERASE_REQ: begin
            wd_d    = '0;
            state_d = ERASE_WAIT_HI;
         end
         ERASE_WAIT_HI, WRITE_WAIT_HI: begin
            if (flash_busy) begin
               wd_d    = '0;
               state_d = (state_q == ERASE_WAIT_HI) ?
                         ERASE_WAIT_LO : WRITE_WAIT_LO;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = ERROR;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         ERASE_WAIT_LO, WRITE_WAIT_LO: begin
            if (!flash_busy) begin
               state_d = (state_q == ERASE_WAIT_LO) ? LOAD : DONE;
            end else if (wd_q == WD_LAST) begin
               err_d   = 1'b1;
               state_d = ERROR;
            end else begin
               wd_d = wd_q + 8'd1;
            end
         end
         LOAD: begin
            if (accept) begin
               if (!phase_q) begin
                  lo_d    = byte_data;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  bdata_d = {byte_data, lo_q};
                  baddr_d = {4'b0, page_q, idx_q};
                  state_d = LOAD_PULSE;
               end
            end
         end
         LOAD_PULSE: begin
            idx_d   = idx_q + 6'd1;
            state_d = (idx_q == LAST_IDX) ? WRITE_REQ : LOAD;
         end
         WRITE_REQ: begin
            wd_d    = '0;
            state_d = WRITE_WAIT_HI;
         end
         DONE:    state_d = IDLE;
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort beats a same-cycle timeout and a same-cycle start.
      if (cmd_abort) begin
         state_d = IDLE;
         err_d   = err_q;
         page_d  = page_q;
      end

      ready_d  = (state_d == LOAD);
      erase_d  = (state_d == ERASE_REQ);
      load_d   = (state_d == LOAD_PULSE);
      write_d  = (state_d == WRITE_REQ);
      done_d   = (state_d == DONE);
      busy_d   = !(state_d inside {IDLE, DONE, ERROR});
      enable_d = busy_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         page_q   <= '0;
         lo_q     <= '0;
         phase_q  <= 1'b0;
         wd_q     <= '0;
         err_q    <= 1'b0;
         bdata_q  <= '0;
         baddr_q  <= '0;
         ready_q  <= 1'b0;
         enable_q <= 1'b0;
         erase_q  <= 1'b0;
         load_q   <= 1'b0;
         write_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         page_q   <= page_d;
         lo_q     <= lo_d;
         phase_q  <= phase_d;
         wd_q     <= wd_d;
         err_q    <= err_d;
         bdata_q  <= bdata_d;
         baddr_q  <= baddr_d;
         ready_q  <= ready_d;
         enable_q <= enable_d;
         erase_q  <= erase_d;
         load_q   <= load_d;
         write_q  <= write_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

`ifdef AXIOMA_FLASH_PROG_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (start_ok) begin
         sum_d = 8'h00;
      end else if (accept && !cmd_abort) begin
         sum_d = sum_q + byte_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q <= 8'h00;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign page_checksum = sum_q;
`else
   assign page_checksum = 8'h00;
`endif

   assign byte_ready        = ready_q;
   assign boot_enable       = enable_q;
   assign boot_erase        = erase_q;
   assign page_buffer_load  = load_q;
   assign page_write_enable = write_q;
   assign page_addr         = page_q;
   assign boot_addr         = baddr_q;
   assign boot_data         = bdata_q;
   assign seq_busy          = busy_q;
   assign seq_done          = done_q;
   assign seq_error         = err_q;

endmodule

// File: tb/tb_axioma_flash_prog_seq.sv
// Directed bench for axioma_flash_prog_seq with a simple flash busy model.
// Honours AXIOMA_FLASH_PROG_CHECKSUM_EN for the expected page sum.
module tb_axioma_flash_prog_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_start;
   logic [5:0]  cmd_page;
   logic        cmd_abort;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        boot_enable;
   logic        boot_erase;
   logic        page_buffer_load;
   logic        page_write_enable;
   logic [5:0]  page_addr;
   logic [15:0] boot_addr;
   logic [15:0] boot_data;
   logic        flash_busy = 1'b0;
   logic        seq_busy;
   logic        seq_done;
   logic        seq_error;
   logic [7:0]  page_checksum;

`ifdef AXIOMA_FLASH_PROG_CHECKSUM_EN
   localparam logic [7:0] EXP_SUM = 8'hC0;
`else
   localparam logic [7:0] EXP_SUM = 8'h00;
`endif

   axioma_flash_prog_seq dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_start         (cmd_start),
      .cmd_page          (cmd_page),
      .cmd_abort         (cmd_abort),
      .byte_data         (byte_data),
      .byte_valid        (byte_valid),
      .byte_ready        (byte_ready),
      .boot_enable       (boot_enable),
      .boot_erase        (boot_erase),
      .page_buffer_load  (page_buffer_load),
      .page_write_enable (page_write_enable),
      .page_addr         (page_addr),
      .boot_addr         (boot_addr),
      .boot_data         (boot_data),
      .flash_busy        (flash_busy),
      .seq_busy          (seq_busy),
      .seq_done          (seq_done),
      .seq_error         (seq_error),
      .page_checksum     (page_checksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Flash model: busy rises 2 cycles after a request, for 16/32 cycles.
   bit no_erase_resp = 1'b0;
   int fw = 0;
   int fr = 0;
   int flen = 0;
   always @(negedge clk) begin
      if (fr > 0) begin
         fr--;
         if (fr == 0) flash_busy = 1'b0;
      end
      if (fw > 0) begin
         fw--;
         if (fw == 0) begin
            flash_busy = 1'b1;
            fr = flen;
         end
      end
      if (boot_erase && !no_erase_resp) begin
         fw = 2;
         flen = 16;
      end
      if (page_write_enable) begin
         fw = 2;
         flen = 32;
      end
   end

   // Output monitor: cumulative counts and captured words.
   int erase_cnt = 0;
   int load_cnt = 0;
   int write_cnt = 0;
   int done_cnt = 0;
   int wide_viol = 0;
   int rdy_viol = 0;
   bit rdy_chk = 1'b0;
   int rbase = 0;
   logic [15:0] words [0:1023];
   logic [15:0] addrs [0:1023];
   logic p_er = 0, p_ld = 0, p_wr = 0, p_dn = 0;
   always @(negedge clk) begin
      if (page_buffer_load) begin
         if (load_cnt < 1024) begin
            words[load_cnt] = boot_data;
            addrs[load_cnt] = boot_addr;
         end
         load_cnt++;
      end
      if (boot_erase) erase_cnt++;
      if (page_write_enable) write_cnt++;
      if (seq_done) done_cnt++;
      if ((boot_erase && p_er) || (page_buffer_load && p_ld) ||
          (page_write_enable && p_wr) || (seq_done && p_dn))
         wide_viol++;
      if (rdy_chk && (load_cnt - rbase) >= 1 && (load_cnt - rbase) < 64)
         if (byte_ready == page_buffer_load) rdy_viol++;
      p_er = boot_erase;
      p_ld = page_buffer_load;
      p_wr = page_write_enable;
      p_dn = seq_done;
   end

   typedef struct {
      logic [5:0]  page;
      int          gap;
      logic [15:0] w0;
      logic [15:0] a0;
      logic [15:0] w63;
      logic [15:0] a63;
   } run_t;

   run_t tbl [3];
   int byte_tmo = 0;

   task automatic start_cmd(input logic [5:0] p);
      @(negedge clk);
      cmd_page  = p;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) byte_tmo++;
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_done(output bit seen);
      int n;
      n = 0;
      while (!seq_done && n < 400) begin
         @(negedge clk);
         n++;
      end
      seen = seq_done;
   endtask

   task automatic do_run(input run_t r);
      int eb, lb, wb, db, rvb, bad;
      bit seen;
      eb = erase_cnt;
      lb = load_cnt;
      wb = write_cnt;
      db = done_cnt;
      rvb = rdy_viol;
      rbase = lb;
      rdy_chk = 1'b1;
      start_cmd(r.page);
      chk("enable_state", {boot_enable, seq_busy, boot_erase}, 3'b110);
      @(negedge clk);
      chk("erase_latency", boot_erase, 1'b1);
      for (int i = 0; i < 128; i++) send_byte(8'(i), r.gap);
      wait_done(seen);
      chk("done_seen", seen, 1'b1);
      chk("checksum", page_checksum, EXP_SUM);
      @(negedge clk);
      chk("idle_after_done", {seq_busy, boot_enable, seq_done}, 3'b000);
      rdy_chk = 1'b0;
      chk("erase_pulses", erase_cnt - eb, 1);
      chk("load_pulses", load_cnt - lb, 64);
      chk("write_pulses", write_cnt - wb, 1);
      chk("done_pulses", done_cnt - db, 1);
      chk("word0", words[lb], r.w0);
      chk("addr0", addrs[lb], r.a0);
      chk("word63", words[lb + 63], r.w63);
      chk("addr63", addrs[lb + 63], r.a63);
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         if (words[lb + i] !== {8'(2 * i + 1), 8'(2 * i)}) bad++;
         if (addrs[lb + i] !== {4'b0, r.page, 6'(i)}) bad++;
      end
      chk("word_stream", bad, 0);
      chk("ready_gaps", rdy_viol - rvb, 0);
      chk("seq_error_clear", seq_error, 1'b0);
   endtask

   initial begin
      int eb, lb, wb, db, n;
      bit seen;
      tbl[0] = '{6'd3, 0, 16'h0100, 16'h00C0, 16'h7F7E, 16'h00FF};
      tbl[1] = '{6'd3, 4, 16'h0100, 16'h00C0, 16'h7F7E, 16'h00FF};
      tbl[2] = '{6'd63, 0, 16'h0100, 16'h0FC0, 16'h7F7E, 16'h0FFF};

      reset      = 1'b1;
      cmd_start  = 1'b0;
      cmd_page   = '0;
      cmd_abort  = 1'b0;
      byte_data  = '0;
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs",
          {byte_ready, boot_enable, boot_erase, page_buffer_load,
           page_write_enable, seq_busy, seq_done, seq_error,
           page_addr, boot_addr, boot_data, page_checksum}, '0);
      reset = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 3; t++) do_run(tbl[t]);

      // Watchdog: no busy after erase.
      no_erase_resp = 1'b1;
      lb = load_cnt;
      start_cmd(6'd7);
      @(negedge clk);
      chk("to_erase", boot_erase, 1'b1);
      repeat (255) @(negedge clk);
      chk("to_before", {seq_error, seq_busy}, 2'b01);
      @(negedge clk);
      chk("to_error", {seq_error, seq_busy, boot_enable}, 3'b100);
      @(negedge clk);
      chk("to_sticky", {seq_error, seq_busy}, 2'b10);
      chk("to_no_load", load_cnt - lb, 0);
      no_erase_resp = 1'b0;
      start_cmd(6'd2);
      chk("to_cleared", {seq_error, seq_busy}, 2'b01);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      chk("abort_early", {seq_busy, boot_erase}, 2'b00);
      repeat (5) @(negedge clk);

      // Abort after 10 words.
      lb = load_cnt;
      wb = write_cnt;
      db = done_cnt;
      start_cmd(6'd3);
      for (int i = 0; i < 20; i++) send_byte(8'(i), 0);
      cmd_abort = 1'b1;
      @(negedge clk);
      cmd_abort = 1'b0;
      chk("abort_idle",
          {seq_busy, boot_enable, page_buffer_load, byte_ready}, 4'b0000);
      repeat (60) @(negedge clk);
      chk("abort_loads", load_cnt - lb, 10);
      chk("abort_no_write", write_cnt - wb, 0);
      chk("abort_no_done", done_cnt - db, 0);

      // Second cmd_start during LOAD is ignored.
      lb = load_cnt;
      wb = write_cnt;
      start_cmd(6'd3);
      for (int i = 0; i < 20; i++) send_byte(8'(i), 0);
      start_cmd(6'd9);
      chk("restart_page", page_addr, 6'd3);
      for (int i = 20; i < 128; i++) send_byte(8'(i), 0);
      wait_done(seen);
      chk("restart_done", seen, 1'b1);
      chk("restart_writes", write_cnt - wb, 1);
      chk("restart_addr63", addrs[lb + 63], 16'h00FF);
      repeat (2) @(negedge clk);

      // Reset in WRITE_WAIT_LO.
      wb = write_cnt;
      db = done_cnt;
      start_cmd(6'd3);
      for (int i = 0; i < 128; i++) send_byte(8'(i), 0);
      n = 0;
      while (!(write_cnt - wb == 1 && flash_busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_write_wait", n < 200, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset_mid_outputs",
          {byte_ready, boot_enable, boot_erase, page_buffer_load,
           page_write_enable, seq_busy, seq_done, seq_error,
           page_addr, boot_addr, boot_data, page_checksum}, '0);
      @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      chk("reset_no_done", done_cnt - db, 0);
      chk("reset_one_write", write_cnt - wb, 1);
      do_run(tbl[0]);

      chk("byte_timeouts", byte_tmo, 0);
      chk("pulse_widths", wide_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
